// File: rtl/rv32i_hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle: ID/EX operands, per-source writeback
// info and data-memory handshake in; operand selects, stage controls and
// performance counters out. Pipeline side uses master, the hazard unit slave.
//
// Ports (master view):
//   de_op/de_rs1/de_rs2         out  instruction currently in ID/EX
//   src_rd/src_regwrite/src_op  out  one packed lane per forwarding source,
//                                    lane 0 = EX/MEM (youngest)
//   dmem_req/dmem_ready         out  data-memory access in MEM and its completion
//   cnt_clear                   out  clears the performance counters
//   forward_a/b/c               in   EX operand selects (0 = regfile, k+1 = source k)
//   stall_front/bubble_em       in   load-use stall controls
//   freeze                      in   hold every pipeline register
//   mem_timeout                 in   sticky memory timeout flag
//   stall_cycles/freeze_cycles  in   saturating performance counters
interface rv32i_hazard_unit_if #(
  parameter int NUM_SRC = 3,
  parameter int SELW    = 2
);
  logic [6:0]           de_op;
  logic [4:0]           de_rs1;
  logic [4:0]           de_rs2;
  logic [5*NUM_SRC-1:0] src_rd;
  logic [NUM_SRC-1:0]   src_regwrite;
  logic [7*NUM_SRC-1:0] src_op;
  logic                 dmem_req;
  logic                 dmem_ready;
  logic                 cnt_clear;

  logic [SELW-1:0]      forward_a;
  logic [SELW-1:0]      forward_b;
  logic [SELW-1:0]      forward_c;
  logic                 stall_front;
  logic                 bubble_em;
  logic                 freeze;
  logic                 mem_timeout;
  logic [31:0]          stall_cycles;
  logic [31:0]          freeze_cycles;

  modport master (
    output de_op, de_rs1, de_rs2, src_rd, src_regwrite, src_op,
           dmem_req, dmem_ready, cnt_clear,
    input  forward_a, forward_b, forward_c, stall_front, bubble_em,
           freeze, mem_timeout, stall_cycles, freeze_cycles
  );

  modport slave (
    input  de_op, de_rs1, de_rs2, src_rd, src_regwrite, src_op,
           dmem_req, dmem_ready, cnt_clear,
    output forward_a, forward_b, forward_c, stall_front, bubble_em,
           freeze, mem_timeout, stall_cycles, freeze_cycles
  );
endinterface

// File: rtl/rv32i_hazard_unit.sv
// Purpose: N-source operand forwarding, load-use stall and data-memory freeze control.
// Latency: selects/stall/bubble/freeze combinational; FSM, timeout flag, counters registered.
// Backpressure: freeze holds all stages while dmem_req && !dmem_ready; load-use stall yields to freeze.
//
// Ports:
//   clk    in  single clock domain
//   reset  in  synchronous, active-high; combinational outputs keep tracking inputs
//   bus    slave side of rv32i_hazard_unit_if (operands, sources, dmem handshake,
//          selects, stage controls, timeout flag, perf counters)
//
// SELW must satisfy 2**SELW > NUM_SRC so that every source index k+1 fits a select.
module rv32i_hazard_unit #(
  parameter int NUM_SRC  = 3,
  parameter int SELW     = 2,
  parameter int LOAD_SRC = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               reset,
  rv32i_hazard_unit_if.slave bus
);

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  // --------------------------------------------------------------------------
  // Operand usage by the ID/EX instruction
  // --------------------------------------------------------------------------
  logic rs1_used;
  logic rs2_used_b;   // rs2 feeds the ALU/compare path (forward_b)
  logic rs2_used_c;   // rs2 is store data (forward_c)

  always_comb begin
    rs1_used   = 1'b0;
    rs2_used_b = 1'b0;
    rs2_used_c = 1'b0;
    case (bus.de_op)
      OPC_BRANCH, OPC_OP: begin
        rs1_used   = 1'b1;
        rs2_used_b = 1'b1;
      end
      OPC_STORE: begin
        rs1_used   = 1'b1;
        rs2_used_c = 1'b1;
      end
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        rs1_used = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Per-source register match
  // --------------------------------------------------------------------------
  // hit_*      : source k writes the register named by the operand (x0 never matches)
  // load_early : source k holds a load whose data is not available yet
  logic [NUM_SRC-1:0] hit_rs1;
  logic [NUM_SRC-1:0] hit_rs2;
  logic [NUM_SRC-1:0] load_early;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [4:0] rd;
    logic [6:0] op;

    assign rd            = bus.src_rd[5*k +: 5];
    assign op            = bus.src_op[7*k +: 7];
    assign hit_rs1[k]    = bus.src_regwrite[k] && (rd != 5'd0) && (rd == bus.de_rs1);
    assign hit_rs2[k]    = bus.src_regwrite[k] && (rd != 5'd0) && (rd == bus.de_rs2);
    assign load_early[k] = (op == OPC_LOAD) && (k < LOAD_SRC);
  end

  // --------------------------------------------------------------------------
  // Priority scan, youngest source wins
  // --------------------------------------------------------------------------
  // The scan runs from oldest to youngest so the last write is the youngest
  // match. The select skips early loads and falls through to an older eligible
  // source, while the hazard flag follows the youngest match only: an early
  // load shadowed by a younger writer of the same register is not a hazard.
  logic [SELW-1:0] sel_rs1;
  logic [SELW-1:0] sel_rs2;
  logic            haz_rs1;
  logic            haz_rs2;

  always_comb begin
    sel_rs1 = '0;
    sel_rs2 = '0;
    haz_rs1 = 1'b0;
    haz_rs2 = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (hit_rs1[k]) begin
        haz_rs1 = load_early[k];
      end
      if (hit_rs1[k] && !load_early[k]) begin
        sel_rs1 = SELW'(k + 1);
      end
      if (hit_rs2[k]) begin
        haz_rs2 = load_early[k];
      end
      if (hit_rs2[k] && !load_early[k]) begin
        sel_rs2 = SELW'(k + 1);
      end
    end
  end

  logic load_use;

  assign load_use = (rs1_used && haz_rs1) ||
                    ((rs2_used_b || rs2_used_c) && haz_rs2);

  assign bus.forward_a = rs1_used   ? sel_rs1 : '0;
  assign bus.forward_b = rs2_used_b ? sel_rs2 : '0;
  assign bus.forward_c = rs2_used_c ? sel_rs2 : '0;

  // --------------------------------------------------------------------------
  // Memory freeze FSM
  // --------------------------------------------------------------------------
  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } mem_state_t;

  mem_state_t state_q;
  mem_state_t state_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_RUN: begin
        if (bus.dmem_req && !bus.dmem_ready) begin
          state_nxt = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ready || !bus.dmem_req) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // Freeze is a pure function of the handshake so that a same-cycle ready
  // never freezes. The stall is dropped under freeze: the whole pipe holds,
  // and the load-use check is re-done once memory completes.
  logic freeze;
  logic stall;
  logic wait_step;

  always_comb begin
    freeze    = bus.dmem_req && !bus.dmem_ready;
    stall     = load_use && !freeze;
    wait_step = (state_q == ST_MEM_WAIT) && (state_nxt == ST_MEM_WAIT);
  end

  assign bus.freeze      = freeze;
  assign bus.stall_front = stall;
  assign bus.bubble_em   = stall;

  // --------------------------------------------------------------------------
  // Wait counter and sticky timeout
  // --------------------------------------------------------------------------
  // Counts cycles spent waiting in MEM_WAIT; the cycle that leaves MEM_WAIT
  // clears it instead. Saturates so a stuck memory cannot wrap it back.
  logic [15:0] wait_cnt;
  logic [15:0] wait_inc;
  logic        mem_timeout;

  assign wait_inc = wait_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 16'd0;
    end else if (state_nxt == ST_RUN) begin
      wait_cnt <= 16'd0;
    end else if (wait_step && (wait_cnt != 16'hFFFF)) begin
      wait_cnt <= wait_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_timeout <= 1'b0;
    end else if (wait_step && (wait_inc == TIMEOUT_CNT)) begin
      mem_timeout <= 1'b1;
    end
  end

  assign bus.mem_timeout = mem_timeout;

  // --------------------------------------------------------------------------
  // Saturating performance counters; clear beats increment
  // --------------------------------------------------------------------------
  logic [31:0] stall_cnt;
  logic [31:0] freeze_cnt;

  always_ff @(posedge clk) begin
    if (reset || bus.cnt_clear) begin
      stall_cnt <= 32'd0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.cnt_clear) begin
      freeze_cnt <= 32'd0;
    end else if (freeze && (freeze_cnt != 32'hFFFF_FFFF)) begin
      freeze_cnt <= freeze_cnt + 32'd1;
    end
  end

  assign bus.stall_cycles  = stall_cnt;
  assign bus.freeze_cycles = freeze_cnt;

endmodule

// File: tb/tb_rv32i_hazard_unit.sv
// Bench for rv32i_hazard_unit: two instances share the stimulus, one with the
// default TIMEOUT and one with TIMEOUT=3 for the timeout flag. Expectations
// are queued when stimulus is applied and compared on the following negedge.
module tb_rv32i_hazard_unit;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic        reset;
  logic [6:0]  de_op;
  logic [4:0]  de_rs1;
  logic [4:0]  de_rs2;
  logic [14:0] src_rd;
  logic [2:0]  src_regwrite;
  logic [20:0] src_op;
  logic        dmem_req;
  logic        dmem_ready;
  logic        cnt_clear;

  rv32i_hazard_unit_if #(.NUM_SRC(3), .SELW(2)) bus_a ();
  rv32i_hazard_unit_if #(.NUM_SRC(3), .SELW(2)) bus_b ();

  assign bus_a.de_op        = de_op;
  assign bus_a.de_rs1       = de_rs1;
  assign bus_a.de_rs2       = de_rs2;
  assign bus_a.src_rd       = src_rd;
  assign bus_a.src_regwrite = src_regwrite;
  assign bus_a.src_op       = src_op;
  assign bus_a.dmem_req     = dmem_req;
  assign bus_a.dmem_ready   = dmem_ready;
  assign bus_a.cnt_clear    = cnt_clear;
  assign bus_b.de_op        = de_op;
  assign bus_b.de_rs1       = de_rs1;
  assign bus_b.de_rs2       = de_rs2;
  assign bus_b.src_rd       = src_rd;
  assign bus_b.src_regwrite = src_regwrite;
  assign bus_b.src_op       = src_op;
  assign bus_b.dmem_req     = dmem_req;
  assign bus_b.dmem_ready   = dmem_ready;
  assign bus_b.cnt_clear    = cnt_clear;

  rv32i_hazard_unit #(.NUM_SRC(3), .SELW(2), .LOAD_SRC(1), .TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  rv32i_hazard_unit #(.NUM_SRC(3), .SELW(2), .LOAD_SRC(1), .TIMEOUT(3)) dut_t (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  typedef struct {
    string       tag;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [1:0]  fc;
    logic        st;
    logic        frz;
    logic        tmo_b;
    logic [31:0] sc;
    logic [31:0] fcn;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference counters, updated at every rising edge from the queued expectations
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_frz   = 32'd0;
  logic        cur_st  = 1'b0;
  logic        cur_frz = 1'b0;
  logic        exp_tmo_b = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_now(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                            input logic [1:0] fc, input logic st, input logic frz);
    exp_t e;
    e.tag   = tag;
    e.fa    = fa;
    e.fb    = fb;
    e.fc    = fc;
    e.st    = st;
    e.frz   = frz;
    e.tmo_b = exp_tmo_b;
    e.sc    = m_stall;
    e.fcn   = m_frz;
    sb.push_back(e);
    cur_st  = st;
    cur_frz = frz;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset || cnt_clear) begin
      m_stall = 32'd0;
      m_frz   = 32'd0;
    end else begin
      if (cur_st && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
      if (cur_frz && (m_frz != 32'hFFFF_FFFF)) m_frz = m_frz + 32'd1;
    end
    cur_st  = 1'b0;
    cur_frz = 1'b0;
    #1;
  endtask

  task automatic idle();
    de_op        = 7'd0;
    de_rs1       = 5'd0;
    de_rs2       = 5'd0;
    src_rd       = '0;
    src_regwrite = '0;
    src_op       = '0;
    dmem_req     = 1'b0;
    dmem_ready   = 1'b0;
    cnt_clear    = 1'b0;
  endtask

  task automatic ins(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2);
    de_op  = op;
    de_rs1 = rs1;
    de_rs2 = rs2;
  endtask

  task automatic set_src(input int k, input logic [4:0] rd, input logic we, input logic [6:0] op);
    src_rd[5*k +: 5]  = rd;
    src_regwrite[k]   = we;
    src_op[7*k +: 7]  = op;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".fwd_a"},      32'(bus_a.forward_a),   32'(e.fa));
      chk({e.tag, ".fwd_b"},      32'(bus_a.forward_b),   32'(e.fb));
      chk({e.tag, ".fwd_c"},      32'(bus_a.forward_c),   32'(e.fc));
      chk({e.tag, ".stall"},      32'(bus_a.stall_front), 32'(e.st));
      chk({e.tag, ".bubble"},     32'(bus_a.bubble_em),   32'(e.st));
      chk({e.tag, ".freeze"},     32'(bus_a.freeze),      32'(e.frz));
      chk({e.tag, ".tmo_a"},      32'(bus_a.mem_timeout), 32'd0);
      chk({e.tag, ".tmo_b"},      32'(bus_b.mem_timeout), 32'(e.tmo_b));
      chk({e.tag, ".stall_cnt"},  bus_a.stall_cycles,     e.sc);
      chk({e.tag, ".freeze_cnt"}, bus_a.freeze_cycles,    e.fcn);
    end
  end

  initial begin
    reset = 1'b1;
    idle();
    tick();

    // reset held: combinational outputs live, registered state stays cleared
    ins(OPC_OP, 5'd5, 5'd0); set_src(0, 5'd5, 1'b1, OPC_OP); dmem_req = 1'b1;
    expect_now("rst_comb", 2'd1, 2'd0, 2'd0, 1'b0, 1'b1); tick();
    reset = 1'b0;

    // forwarding priority
    idle(); ins(OPC_OP, 5'd5, 5'd6);
    set_src(0, 5'd5, 1'b1, OPC_OP); set_src(1, 5'd6, 1'b1, OPC_OP); set_src(2, 5'd6, 1'b1, OPC_OP);
    expect_now("fwd_op", 2'd1, 2'd2, 2'd0, 1'b0, 1'b0); tick();
    de_op = OPC_STORE;
    expect_now("fwd_store", 2'd1, 2'd0, 2'd2, 1'b0, 1'b0); tick();

    // load-use, then the load advances to the forwarding source
    idle(); ins(OPC_OP, 5'd7, 5'd0); set_src(0, 5'd7, 1'b1, OPC_LOAD);
    expect_now("ld_use", 2'd0, 2'd0, 2'd0, 1'b1, 1'b0); tick();
    idle(); ins(OPC_OP, 5'd7, 5'd0); set_src(1, 5'd7, 1'b1, OPC_LOAD);
    expect_now("ld_fwd", 2'd2, 2'd0, 2'd0, 1'b0, 1'b0); tick();

    // x0 and non-user opcodes
    idle(); ins(OPC_OP, 5'd0, 5'd0);
    set_src(0, 5'd0, 1'b1, OPC_OP); set_src(1, 5'd0, 1'b1, OPC_LOAD); set_src(2, 5'd0, 1'b1, OPC_OP);
    expect_now("x0", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0); tick();
    idle(); ins(OPC_LUI, 5'd5, 5'd6); set_src(0, 5'd5, 1'b1, OPC_OP); set_src(1, 5'd6, 1'b1, OPC_OP);
    expect_now("lui", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0); tick();

    // early load on rs2 still lets an older eligible source drive the select
    idle(); ins(OPC_BRANCH, 5'd3, 5'd4);
    set_src(0, 5'd4, 1'b1, OPC_LOAD); set_src(1, 5'd3, 1'b1, OPC_OP); set_src(2, 5'd4, 1'b1, OPC_OP);
    expect_now("br_ld", 2'd2, 2'd3, 2'd0, 1'b1, 1'b0); tick();
    idle(); ins(OPC_JALR, 5'd0, 5'd9); set_src(0, 5'd9, 1'b1, OPC_LOAD);
    expect_now("jalr_rs2", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0); tick();
    idle(); ins(OPC_STORE, 5'd1, 5'd8); set_src(0, 5'd8, 1'b1, OPC_LOAD);
    expect_now("st_ld", 2'd0, 2'd0, 2'd0, 1'b1, 1'b0); tick();
    idle(); ins(OPC_OP, 5'd5, 5'd0); set_src(0, 5'd5, 1'b0, OPC_OP);
    expect_now("no_we", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0); tick();

    // ready in the request cycle: no freeze, stall allowed
    idle(); ins(OPC_OP, 5'd7, 5'd0); set_src(0, 5'd7, 1'b1, OPC_LOAD);
    dmem_req = 1'b1; dmem_ready = 1'b1;
    expect_now("req_rdy", 2'd0, 2'd0, 2'd0, 1'b1, 1'b0); tick();

    // wait counter restarts on every return to RUN (req drop, then ready)
    idle();
    for (int i = 0; i < 2; i++) begin
      dmem_req = 1'b1;
      expect_now("burst1", 2'd0, 2'd0, 2'd0, 1'b0, 1'b1); tick();
    end
    dmem_req = 1'b0;
    expect_now("burst1_drop", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      dmem_req = 1'b1;
      expect_now("burst2", 2'd0, 2'd0, 2'd0, 1'b0, 1'b1); tick();
    end
    dmem_ready = 1'b1;
    expect_now("burst2_rdy", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0); tick();
    idle(); cnt_clear = 1'b1;
    expect_now("clear", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0); tick();

    // 4-cycle freeze over a pending load-use
    for (int i = 0; i < 4; i++) begin
      idle(); ins(OPC_OP, 5'd7, 5'd0); set_src(0, 5'd7, 1'b1, OPC_LOAD); dmem_req = 1'b1;
      expect_now("frz4", 2'd0, 2'd0, 2'd0, 1'b0, 1'b1); tick();
    end
    exp_tmo_b = 1'b1;
    idle(); ins(OPC_OP, 5'd7, 5'd0); dmem_req = 1'b1; dmem_ready = 1'b1;
    expect_now("frz4_rdy", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0); tick();
    idle();
    expect_now("frz4_after", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0); tick();

    // reset clears the sticky timeout
    reset = 1'b1;
    expect_now("rst_tmo", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0); tick();
    reset = 1'b0; exp_tmo_b = 1'b0;
    expect_now("post_rst", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0); tick();

    // timeout: flag rises after the third waiting cycle and sticks
    for (int i = 0; i < 5; i++) begin
      dmem_req = 1'b1;
      if (i == 4) exp_tmo_b = 1'b1;
      expect_now("tmo_wait", 2'd0, 2'd0, 2'd0, 1'b0, 1'b1); tick();
    end
    dmem_ready = 1'b1;
    expect_now("tmo_rdy", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0); tick();
    idle();
    expect_now("tmo_sticky", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0); tick();

    // reset in the middle of a wait returns the FSM to RUN
    for (int i = 0; i < 2; i++) begin
      dmem_req = 1'b1;
      expect_now("mid_wait", 2'd0, 2'd0, 2'd0, 1'b0, 1'b1); tick();
    end
    reset = 1'b1;
    expect_now("mid_rst", 2'd0, 2'd0, 2'd0, 1'b0, 1'b1); tick();
    reset = 1'b0; exp_tmo_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_now("mid_rewait", 2'd0, 2'd0, 2'd0, 1'b0, 1'b1); tick();
    end
    dmem_ready = 1'b1;
    expect_now("mid_rdy", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0); tick();
    idle();
    expect_now("mid_after", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0); tick();

    // stall counter near the top: saturates, then clear wins over a stall
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    m_stall = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) begin
      idle(); ins(OPC_OP, 5'd7, 5'd0); set_src(0, 5'd7, 1'b1, OPC_LOAD);
      if (i == 3) cnt_clear = 1'b1;
      expect_now("sat", 2'd0, 2'd0, 2'd0, 1'b1, 1'b0); tick();
    end
    idle();
    expect_now("sat_clr", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0); tick();

    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_hazard_unit.md
# rv32i_hazard_unit

Parametrised forwarding and hazard controller for the rv32i pipeline. It replaces the fixed three-source forwarding unit with one that supports:
- N forwarding sources;
- load-use stall generation with a configurable load-data source depth;
- a whole-pipeline freeze FSM for a variable-latency data memory, with timeout detection;
- saturating stall/freeze performance counters.

It sits beside the ID/EX register and drives the EX operand muxes and the stage-register enables.

## Interface
Parameters:
- NUM_SRC, 3: number of forwarding sources; index 0 = EX/MEM (youngest), increasing index = older (MEM/WB, write buffer, ...).
- SELW, 2: forward select width; must satisfy 2^SELW > NUM_SRC.
- LOAD_SRC, 1: lowest source index at which load data is valid. Loads at index < LOAD_SRC cannot forward.
- TIMEOUT, 255: MEM_WAIT cycles before mem_timeout is raised (1..65535).

Ports:
- clk  in  1  clock. One clock domain; reset is synchronous and active-high.
- reset  in  1  synchronous active-high reset.
- de_op  in  7  opcode of the instruction in ID/EX.
- de_rs1, de_rs2  in  5 each  source registers of the instruction in ID/EX.
- src_rd  in  5*NUM_SRC  destination register per source; source k occupies bits [5k+4:5k].
- src_regwrite  in  NUM_SRC  register-write enable per source.
- src_op  in  7*NUM_SRC  opcode per source; source k occupies bits [7k+6:7k].
- dmem_req  in  1  a load or store in MEM is accessing data memory this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- cnt_clear  in  1  synchronously clears both performance counters.
- forward_a, forward_b, forward_c  out  SELW each  operand selects. 0 = register file; k+1 = source k.
- stall_front  out  1  hold PC, IF/ID and ID/EX.
- bubble_em  out  1  load a NOP into EX/MEM.
- freeze  out  1  hold every pipeline register.
- mem_timeout  out  1  sticky error flag.
- stall_cycles, freeze_cycles  out  32 each  performance counters.

## Operation
Opcode classes:
- rs1 users: BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, JALR 1100111.
- rs2 users for forward_b: BRANCH, OP.
- rs2 user for forward_c: STORE.
- Any other opcode drives 0 on the corresponding select.

Source k is eligible to forward register r when all of the following hold:
- src_regwrite[k] = 1;
- src_rd[k] = r and r != 0;
- the source is not a load with k < LOAD_SRC.

Selects:
- Each select = k+1 for the lowest eligible k, otherwise 0.
- forward_b and forward_c are computed identically from de_rs2, gated by their opcode class.

Load-use hazard:
- Condition: an operand in use by the ID/EX instruction matches src_rd[k] with src_regwrite[k] = 1, src_rd[k] != 0, src_op[k] = LOAD, k < LOAD_SRC, and no younger source j < k also matches.
- Response: stall_front = 1, bubble_em = 1.

Memory FSM (states RUN, MEM_WAIT):
- RUN -> MEM_WAIT when dmem_req && !dmem_ready.
- MEM_WAIT -> RUN when dmem_ready, or when dmem_req is deasserted.
- freeze = dmem_req && !dmem_ready in either state.
- While freeze = 1, stall_front and bubble_em are forced to 0. Forward selects are still driven normally.

Wait counter (16-bit):
- Cleared on entry to RUN; increments each cycle in MEM_WAIT.
- When it reaches TIMEOUT, mem_timeout is set. mem_timeout stays set until reset.

Performance counters:
- stall_cycles increments on every cycle with stall_front = 1; freeze_cycles on every cycle with freeze = 1.
- Both saturate at 0xFFFFFFFF.
- cnt_clear has priority over increment.

## Timing
- Forward selects, stall_front, bubble_em and freeze are combinational from inputs, valid in the same cycle.
- The FSM state, wait counter, mem_timeout and perf counters update on the rising clk edge.
- Load-use stall length = LOAD_SRC − k cycles for a load at source k. The hazard re-evaluates each cycle as the load advances.
- Reset values: state RUN, wait counter 0, mem_timeout 0, stall_cycles 0, freeze_cycles 0.
- With reset asserted, all combinational outputs still reflect inputs; registered state is held at its reset values.
- Reset mid-MEM_WAIT returns the FSM to RUN on the next edge, regardless of dmem_ready.
- dmem_ready in the same cycle as the request: no freeze and no state change.

## Test plan
- de_op=OP, rs1=5, rs2=6; src0 rd=5 (OP), src1 rd=6, src2 rd=6, all regwrite=1 -> forward_a=1, forward_b=2, forward_c=0.
- de_op=OP, rs1=7; src0 rd=7 LOAD, LOAD_SRC=1 -> stall_front=1, bubble_em=1, forward_a=0. Next cycle src1 rd=7 LOAD -> forward_a=2, no stall. stall_cycles=1.
- rs1=0 with every src_rd=0 and regwrite=1 -> all selects 0, no stall. de_op=LUI with a matching src -> selects 0.
- dmem_req=1, dmem_ready=0 for 4 cycles, then ready=1:
  - freeze=1 for 4 cycles and stall_front suppressed;
  - freeze_cycles=4; FSM returns to RUN; mem_timeout=0.
- TIMEOUT=3, ready held low for 5 cycles -> mem_timeout=1 after the 3rd MEM_WAIT cycle; it stays 1 after ready, until reset.
- Preload stall_cycles to 0xFFFFFFFF via continuous stall -> it holds. cnt_clear together with a stall -> counter reads 0.
